// File: rtl/tbu_b213_pkg.sv
// Shared types and constants for the b213 traceback unit.
// Used by tbu_b213, its interface and the BEST_STATE_EN argmin tree.
package tbu_b213_pkg;

  localparam int NSTATES      = 8;
  localparam int SW           = 3;
  localparam int TB_DEPTH_DEF = 16;

  typedef enum logic {
    FILL,
    TRACE
  } tb_fsm_e;

  typedef logic [SW-1:0] state_t;

  // Predecessor of s on the trellis: {decision bit, s[2:1]}.
  function automatic state_t tb_pred(
    input logic [NSTATES-1:0] bx,
    input state_t             s
  );
    return {bx[s], s[2:1]};
  endfunction

endpackage

// File: rtl/tbu_b213_if.sv
// ACS-to-traceback stage handshake for the b213 decoder.
// master = ACS side, slave = traceback unit.
interface tbu_b213_if #(
  parameter int W = 8
);
  import tbu_b213_pkg::*;

  logic                 ae;
  logic [NSTATES-1:0]   acs_Bx_in;
  logic [NSTATES*W-1:0] acs_ppm_in;
  logic                 tb_ready;

  modport master (
    output ae,
    output acs_Bx_in,
    output acs_ppm_in,
    input  tb_ready
  );

  modport slave (
    input  ae,
    input  acs_Bx_in,
    input  acs_ppm_in,
    output tb_ready
  );

endinterface

// File: rtl/tbu_b213_bmin8.sv
// 8-way unsigned argmin tree, lowest index wins ties.
// Only built when BEST_STATE_EN is defined.
`ifdef BEST_STATE_EN
module bmin8_b213
  import tbu_b213_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [NSTATES*W-1:0] ppm,
  output state_t               idx
);

  logic [W-1:0] v1 [4];
  state_t       i1 [4];
  logic [W-1:0] v2 [2];
  state_t       i2 [2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (ppm[(2*i+1)*W +: W] < ppm[2*i*W +: W]) begin
        v1[i] = ppm[(2*i+1)*W +: W];
        i1[i] = state_t'(2*i+1);
      end else begin
        v1[i] = ppm[2*i*W +: W];
        i1[i] = state_t'(2*i);
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (v1[2*j+1] < v1[2*j]) begin
        v2[j] = v1[2*j+1];
        i2[j] = i1[2*j+1];
      end else begin
        v2[j] = v1[2*j];
        i2[j] = i1[2*j];
      end
    end
    if (v2[1] < v2[0]) idx = i2[1];
    else               idx = i2[0];
  end

endmodule
`endif

// File: rtl/tbu_b213.sv
// Traceback survivor memory for the (2,1,3) Viterbi decoder.
// Define BEST_STATE_EN to start traceback at the argmin path metric.
module tbu_b213
  import tbu_b213_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int W        = 8
) (
  input  logic      clock,
  input  logic      reset,
  tbu_b213_if.slave acs,
  output logic      dec_valid,
  output logic      dec_bit,
  output logic      tb_ovf
);

  localparam int PW = $clog2(TB_DEPTH);
  localparam int CW = $clog2(TB_DEPTH + 1);

  localparam logic [PW-1:0] LAST =
    PW'(TB_DEPTH - 1);
  localparam logic [PW-1:0] STEP_END =
    PW'(TB_DEPTH - 2);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(TB_DEPTH - 1);

  tb_fsm_e fsm_q, fsm_d;

  logic [NSTATES-1:0] mem [TB_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      step;
  logic [CW-1:0]      count;
  state_t             tb_state;
  state_t             start_state;
  state_t             next_state;

  logic tb_ready;
  logic accept;
  logic full;
  logic last;

  assign tb_ready     = (fsm_q != TRACE);
  assign acs.tb_ready = tb_ready;
  assign accept       = acs.ae && tb_ready;
  assign full         = accept &&
                        (count == FULL_M1);
  assign last         = (fsm_q == TRACE) &&
                        (step == STEP_END);
  assign next_state   = tb_pred(mem[rd_ptr],
                                tb_state);

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      FILL:  if (full) fsm_d = TRACE;
      TRACE: if (last) fsm_d = FILL;
      default: fsm_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= acs.acs_Bx_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      step      <= '0;
      count     <= '0;
      tb_state  <= '0;
      dec_valid <= 1'b0;
      dec_bit   <= 1'b0;
      tb_ovf    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      dec_valid <= 1'b0;
      if (acs.ae && !tb_ready) tb_ovf <= 1'b1;
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST) ? '0
                                   : wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (full) begin
        rd_ptr   <= wr_ptr;
        tb_state <= start_state;
        step     <= '0;
      end
      if (fsm_q == TRACE) begin
        tb_state <= next_state;
        rd_ptr   <= (rd_ptr == '0) ? LAST
                                   : rd_ptr - 1'b1;
        step     <= step + 1'b1;
        // Final column reached: emit oldest stage, free its slot.
        if (last) begin
          dec_bit   <= next_state[0];
          dec_valid <= 1'b1;
          count     <= FULL_M1;
        end
      end
    end
  end

`ifdef BEST_STATE_EN
  state_t best;

  bmin8_b213 #(
    .W (W)
  ) u_bmin (
    .ppm (acs.acs_ppm_in),
    .idx (best)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      start_state <= '0;
    else if (accept) start_state <= best;
  end
`else
  logic unused_ppm;
  assign unused_ppm  = ^acs.acs_ppm_in;
  assign start_state = '0;
`endif

endmodule

// File: tb/tb_tbu_b213.sv
// Directed self-checking bench for tbu_b213.
// Three instances: L=16, L=2 and L=5.
module tb_tbu_b213;
  import tbu_b213_pkg::*;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tbu_b213_if #(.W(W)) if16 ();
  tbu_b213_if #(.W(W)) if2 ();
  tbu_b213_if #(.W(W)) if5 ();

  logic dv16, db16, ov16;
  logic dv2, db2, ov2;
  logic dv5, db5, ov5;

  tbu_b213 #(.TB_DEPTH(16), .W(W)) dut16 (
    .clock     (clock),
    .reset     (reset),
    .acs       (if16),
    .dec_valid (dv16),
    .dec_bit   (db16),
    .tb_ovf    (ov16)
  );

  tbu_b213 #(.TB_DEPTH(2), .W(W)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .acs       (if2),
    .dec_valid (dv2),
    .dec_bit   (db2),
    .tb_ovf    (ov2)
  );

  tbu_b213 #(.TB_DEPTH(5), .W(W)) dut5 (
    .clock     (clock),
    .reset     (reset),
    .acs       (if5),
    .dec_valid (dv5),
    .dec_bit   (db5),
    .tb_ovf    (ov5)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    if16.ae = 1'b0;
    if2.ae  = 1'b0;
    if5.ae  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if16.tb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b exp 1",
               if16.tb_ready);
    end
    checks++;
    if (dv16 !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0", dv16);
    end
    checks++;
    if (db16 !== 1'b0) begin
      errors++;
      $display("FAIL rst_bit got %b exp 0", db16);
    end
    checks++;
    if (ov16 !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf got %b exp 0", ov16);
    end
    checks++;
    if (if2.tb_ready !== 1'b1 ||
        if5.tb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_small got %b%b exp 11",
               if2.tb_ready, if5.tb_ready);
    end
  endtask

  task automatic test_fill_zero();
    int sent = 0;
    int low = 0;
    int last_c = 0;
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (dv16) begin
        checks++;
        if (db16 !== 1'b0) begin
          errors++;
          $display("FAIL zero_bit got %b exp 0", db16);
        end
        checks++;
        if (pulses == 0) begin
          if (low !== 15) begin
            errors++;
            $display("FAIL zero_lat got %0d exp 15",
                     low);
          end
        end else if (c - last_c !== 16) begin
          errors++;
          $display("FAIL zero_gap got %0d exp 16",
                   c - last_c);
        end
        last_c = c;
        pulses++;
      end
      if (!if16.tb_ready && pulses == 0) low++;
      if (if16.tb_ready && sent < 26) begin
        if16.ae = 1'b1;
        if16.acs_Bx_in = 8'h00;
        sent++;
      end else begin
        if16.ae = 1'b0;
      end
      tick();
    end
    if16.ae = 1'b0;
    checks++;
    if (pulses !== 11) begin
      errors++;
      $display("FAIL zero_count got %0d exp 11",
               pulses);
    end
    checks++;
    if (ov16 !== 1'b0) begin
      errors++;
      $display("FAIL zero_ovf got %b exp 0", ov16);
    end
  endtask

  task automatic test_all_ones();
    int sent = 0;
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      if (dv16) begin
        checks++;
        if (db16 !== 1'b1) begin
          errors++;
          $display("FAIL ones_bit got %b exp 1", db16);
        end
        pulses++;
      end
      if (if16.tb_ready && sent < 20) begin
        if16.ae = 1'b1;
        if16.acs_Bx_in = 8'hFF;
        sent++;
      end else begin
        if16.ae = 1'b0;
      end
      tick();
    end
    if16.ae = 1'b0;
    checks++;
    if (pulses !== 5) begin
      errors++;
      $display("FAIL ones_count got %0d exp 5",
               pulses);
    end
  endtask

  task automatic test_best_state();
    int sent = 0;
    int pulses = 0;
    logic exp_bit;
`ifdef BEST_STATE_EN
    exp_bit = 1'b1;
`else
    exp_bit = 1'b0;
`endif
    do_reset();
    for (int s = 0; s < 8; s++)
      if2.acs_ppm_in[s*W +: W] = (s == 3) ? 8'd1
                                          : 8'd9;
    for (int c = 0; c < 40; c++) begin
      if (dv2) begin
        checks++;
        if (db2 !== exp_bit) begin
          errors++;
          $display("FAIL best_bit got %b exp %b",
                   db2, exp_bit);
        end
        pulses++;
      end
      if (if2.tb_ready && sent < 4) begin
        if2.ae = 1'b1;
        if2.acs_Bx_in = 8'h00;
        sent++;
      end else begin
        if2.ae = 1'b0;
      end
      tick();
    end
    if2.ae = 1'b0;
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL best_count got %0d exp 3",
               pulses);
    end
  endtask

  task automatic test_hold_ae();
    logic u [64];
    int k = 0;
    int idx = 0;
    int low_c = -1;
    logic b;
    for (int i = 0; i < 64; i++) u[i] = 1'($urandom);
    do_reset();
    for (int c = 0; c < 140; c++) begin
      if (dv16) begin
        checks++;
        if (db16 !== u[idx]) begin
          errors++;
          $display("FAIL hold_bit[%0d] got %b exp %b",
                   idx, db16, u[idx]);
        end
        idx++;
      end
      if (!if16.tb_ready && low_c < 0) begin
        low_c = c;
        checks++;
        if (ov16 !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got %b exp 0", ov16);
        end
      end else if (low_c >= 0 && c == low_c + 1) begin
        checks++;
        if (ov16 !== 1'b1) begin
          errors++;
          $display("FAIL ovf_rise got %b exp 1", ov16);
        end
      end
      if (c < 120) begin
        if16.ae = 1'b1;
        if (if16.tb_ready) begin
          b = (k >= 3) ? u[k-3] : 1'b0;
          if16.acs_Bx_in = {8{b}};
          k++;
        end else begin
          if16.acs_Bx_in = 8'($urandom);
        end
      end else begin
        if16.ae = 1'b0;
      end
      tick();
    end
    if16.ae = 1'b0;
    checks++;
    if (idx !== k - 15) begin
      errors++;
      $display("FAIL hold_count got %0d exp %0d",
               idx, k - 15);
    end
    checks++;
    if (ov16 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b exp 1", ov16);
    end
  endtask

  task automatic test_reset_mid_trace();
    int pulses = 0;
    int wait_c = -1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if16.ae = 1'b1;
      if16.acs_Bx_in = 8'h00;
      tick();
    end
    if16.ae = 1'b0;
    repeat (7) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (if16.tb_ready !== 1'b1 || dv16 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got rdy=%b dv=%b exp 1 0",
               if16.tb_ready, dv16);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (dv16) pulses++;
      tick();
    end
    for (int c = 0; c < 15; c++) begin
      if16.ae = 1'b1;
      tick();
    end
    if16.ae = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (dv16) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_spurious got %0d exp 0",
               pulses);
    end
    if16.ae = 1'b1;
    tick();
    if16.ae = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (dv16 && wait_c < 0) wait_c = c;
      tick();
    end
    checks++;
    if (wait_c !== 16) begin
      errors++;
      $display("FAIL mid_refill got %0d exp 16",
               wait_c);
    end
  endtask

  task automatic test_wrap();
    logic u [23];
    int k = 0;
    int idx = 0;
    logic b;
    for (int i = 0; i < 23; i++) u[i] = 1'($urandom);
    do_reset();
    if5.acs_ppm_in = '0;
    for (int c = 0; c < 130; c++) begin
      if (dv5) begin
        checks++;
        if (idx >= 19 || db5 !== u[idx]) begin
          errors++;
          $display("FAIL wrap_bit[%0d] got %b exp %b",
                   idx, db5, u[idx % 23]);
        end
        idx++;
      end
      if (if5.tb_ready && k < 23) begin
        b = (k >= 3) ? u[k-3] : 1'b0;
        if5.ae = 1'b1;
        if5.acs_Bx_in = {8{b}};
        k++;
      end else begin
        if5.ae = 1'b0;
      end
      tick();
    end
    if5.ae = 1'b0;
    checks++;
    if (idx !== 19) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 19", idx);
    end
    checks++;
    if (ov5 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf got %b exp 0", ov5);
    end
  endtask

  initial begin
    if16.ae = 1'b0;
    if16.acs_Bx_in = '0;
    if16.acs_ppm_in = '0;
    if2.ae = 1'b0;
    if2.acs_Bx_in = '0;
    if2.acs_ppm_in = '0;
    if5.ae = 1'b0;
    if5.acs_Bx_in = '0;
    if5.acs_ppm_in = '0;
    test_reset();
    test_fill_zero();
    test_all_ones();
    test_best_state();
    test_hold_ae();
    test_reset_mid_trace();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
